// File: rtl/sccb_init_seq_pkg.sv
// sccb_init_seq_pkg: shared FSM states, init-table markers and the ms cycle divider
package sccb_init_seq_pkg;
  typedef enum logic [3:0] {IDLE, FETCH, DECODE, XFER, WAIT_DONE, RELEASE, DELAY, HOST, FINISH} state_e;
  localparam logic [15:0] END_MARKER = 16'hFFFF;
  localparam logic [7:0] DELAY_TAG = 8'hFE;
  function automatic int ms_div(input int freq);
    return (freq / 1000) > 0 ? freq / 1000 : 1;
  endfunction
endpackage

// File: rtl/sccb_init_seq_ms_timer.sv
// sccb_ms_timer: millisecond down-counter, load a ms count and expired rises once it has elapsed
module sccb_ms_timer
  import sccb_init_seq_pkg::*;
#(
  parameter int CYC_PER_MS = ms_div(10_000_000)
) (
  input  logic       xclk,
  input  logic       resetn,
  input  logic       load,
  input  logic [7:0] ms,
  output logic       expired
);
  localparam int SW = $clog2(CYC_PER_MS + 1);
  localparam logic [SW-1:0] SUB_MAX = SW'(CYC_PER_MS - 1);
  logic [7:0] ms_q, ms_d;
  logic [SW-1:0] sub_q, sub_d;
  always_comb begin
    ms_d = load ? ms : (ms_q != 8'd0 && sub_q == '0) ? ms_q - 1'b1 : ms_q;
    sub_d = (load || sub_q == '0) ? SUB_MAX : (ms_q != 8'd0) ? sub_q - 1'b1 : sub_q;
  end
  always_ff @(posedge xclk) begin
    if (!resetn) begin
      ms_q <= '0;
      sub_q <= '0;
    end else begin
      ms_q <= ms_d;
      sub_q <= sub_d;
    end
  end
  assign expired = ms_q == 8'd0;
endmodule

// File: rtl/sccb_init_seq.sv
// sccb_init_seq: walks a camera init table over SCCB and serves host register access; define SCCB_READBACK_EN to verify each table write by readback
module sccb_init_seq
  import sccb_init_seq_pkg::*;
#(
  parameter int         XCLK_FREQ   = 10_000_000,
  parameter logic [7:0] DEV_ID      = 8'h42,
  parameter int         TBL_AW      = 8,
  parameter int         TIMEOUT_CYC = 100_000
) (
  input  logic              xclk,
  input  logic              resetn,
  input  logic              go,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [15:0]       tbl_data,
  input  logic              host_req,
  input  logic              host_rw,
  input  logic [7:0]        host_addr,
  input  logic [7:0]        host_wdata,
  output logic              host_ack,
  output logic [7:0]        host_rdata,
  output logic              sccb_start,
  output logic              sccb_rw,
  output logic [7:0]        sccb_ip_addr,
  output logic [7:0]        sccb_sub_addr,
  output logic [7:0]        sccb_data_in,
  input  logic [7:0]        sccb_data_out,
  input  logic              sccb_done,
  output logic              busy,
  output logic              init_done,
  output logic              error,
  output logic [TBL_AW-1:0] err_addr
);
`ifdef SCCB_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  state_e state_q, state_d;
  logic [TBL_AW-1:0] tbl_addr_q, tbl_addr_d, err_addr_q, err_addr_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic go_q, init_done_q, init_done_d, error_q, error_d;
  logic host_mode_q, host_mode_d, rd_phase_q, rd_phase_d, abort_q, abort_d;
  logic start_q, start_d, rw_q, rw_d, ack_q, ack_d;
  logic [7:0] ip_q, ip_d, sub_q, sub_d, data_q, data_d, rdata_q, rdata_d;
  logic go_rise, tmr_load, tmr_exp, adv;
  assign go_rise = go & ~go_q;
  sccb_ms_timer #(.CYC_PER_MS(ms_div(XCLK_FREQ))) u_timer (
    .xclk(xclk), .resetn(resetn), .load(tmr_load), .ms(tbl_data[7:0]), .expired(tmr_exp)
  );
  always_comb begin
    state_d = state_q;
    tbl_addr_d = tbl_addr_q;
    err_addr_d = err_addr_q;
    tmo_d = tmo_q;
    init_done_d = init_done_q;
    error_d = error_q;
    host_mode_d = host_mode_q;
    rd_phase_d = rd_phase_q;
    abort_d = abort_q;
    start_d = start_q;
    rw_d = rw_q;
    ack_d = 1'b0;
    ip_d = ip_q;
    sub_d = sub_q;
    data_d = data_q;
    rdata_d = rdata_q;
    tmr_load = 1'b0;
    adv = 1'b0;
    case (state_q)
      IDLE: if (go_rise) begin
        tbl_addr_d = '0;
        init_done_d = 1'b0;
        error_d = 1'b0;
        host_mode_d = 1'b0;
        state_d = FETCH;
      end else if (host_req) begin
        host_mode_d = 1'b1;
        rd_phase_d = 1'b0;
        rw_d = host_rw;
        sub_d = host_addr;
        data_d = host_wdata;
        state_d = HOST;
      end
      FETCH: state_d = DECODE;
      DECODE: if (tbl_data == END_MARKER) begin
        init_done_d = 1'b1;
        state_d = FINISH;
      end else if (tbl_data[15:8] == DELAY_TAG) begin
        tmr_load = 1'b1;
        state_d = DELAY;
      end else begin
        rw_d = 1'b0;
        sub_d = tbl_data[15:8];
        data_d = tbl_data[7:0];
        rd_phase_d = 1'b0;
        state_d = XFER;
      end
      HOST: state_d = XFER;
      XFER: begin
        ip_d = DEV_ID;
        start_d = 1'b1;
        tmo_d = '0;
        abort_d = 1'b0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: if (sccb_done) begin
        start_d = 1'b0;
        state_d = RELEASE;
        if (host_mode_q && rw_q) rdata_d = sccb_data_out;
        if (READBACK && rd_phase_q && sccb_data_out != data_q) begin
          error_d = 1'b1;
          err_addr_d = error_q ? err_addr_q : tbl_addr_q;
        end
      end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
        start_d = 1'b0;
        abort_d = 1'b1;
        error_d = 1'b1;
        state_d = RELEASE;
        if (!host_mode_q && !error_q) err_addr_d = tbl_addr_q;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
      RELEASE: if (!sccb_done) begin
        if (host_mode_q || abort_q) begin
          ack_d = host_mode_q;
          state_d = IDLE;
        end else if (READBACK && !rd_phase_q) begin
          rd_phase_d = 1'b1;
          rw_d = 1'b1;
          state_d = XFER;
        end else begin
          adv = 1'b1;
        end
      end
      DELAY: adv = tmr_exp;
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (adv && &tbl_addr_q) begin
      error_d = 1'b1;
      err_addr_d = error_q ? err_addr_q : tbl_addr_q;
      state_d = IDLE;
    end else if (adv) begin
      tbl_addr_d = tbl_addr_q + 1'b1;
      state_d = FETCH;
    end
  end
  always_ff @(posedge xclk) begin
    if (!resetn) begin
      state_q <= IDLE;
      tbl_addr_q <= '0;
      err_addr_q <= '0;
      tmo_q <= '0;
      go_q <= 1'b0;
      init_done_q <= 1'b0;
      error_q <= 1'b0;
      host_mode_q <= 1'b0;
      rd_phase_q <= 1'b0;
      abort_q <= 1'b0;
      start_q <= 1'b0;
      rw_q <= 1'b0;
      ack_q <= 1'b0;
      ip_q <= '0;
      sub_q <= '0;
      data_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      tbl_addr_q <= tbl_addr_d;
      err_addr_q <= err_addr_d;
      tmo_q <= tmo_d;
      go_q <= go;
      init_done_q <= init_done_d;
      error_q <= error_d;
      host_mode_q <= host_mode_d;
      rd_phase_q <= rd_phase_d;
      abort_q <= abort_d;
      start_q <= start_d;
      rw_q <= rw_d;
      ack_q <= ack_d;
      ip_q <= ip_d;
      sub_q <= sub_d;
      data_q <= data_d;
      rdata_q <= rdata_d;
    end
  end
  assign tbl_addr = tbl_addr_q;
  assign host_ack = ack_q;
  assign host_rdata = rdata_q;
  assign sccb_start = start_q;
  assign sccb_rw = rw_q;
  assign sccb_ip_addr = ip_q;
  assign sccb_sub_addr = sub_q;
  assign sccb_data_in = data_q;
  assign busy = state_q != IDLE;
  assign init_done = init_done_q;
  assign error = error_q;
  assign err_addr = err_addr_q;
endmodule

// File: tb/tb_sccb_init_seq.sv
// tb_sccb_init_seq: scoreboard bench with an SCCB slave model and a synchronous init-table ROM
module tb_sccb_init_seq;
  localparam int TBL_AW = 8;
  localparam int TMO = 200;
  logic xclk = 1'b0;
  logic resetn = 1'b0;
  logic go = 1'b0;
  logic [TBL_AW-1:0] tbl_addr, err_addr;
  logic [15:0] tbl_data;
  logic host_req, host_rw, host_ack;
  logic [7:0] host_addr, host_wdata, host_rdata;
  logic sccb_start, sccb_rw, sccb_done;
  logic [7:0] sccb_ip_addr, sccb_sub_addr, sccb_data_in, sccb_data_out;
  logic busy, init_done, error;
  always #5 xclk = ~xclk;
  sccb_init_seq #(.XCLK_FREQ(10_000), .DEV_ID(8'h42), .TBL_AW(TBL_AW), .TIMEOUT_CYC(TMO)) dut (
    .xclk(xclk), .resetn(resetn), .go(go), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .host_req(host_req), .host_rw(host_rw), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .sccb_start(sccb_start), .sccb_rw(sccb_rw), .sccb_ip_addr(sccb_ip_addr),
    .sccb_sub_addr(sccb_sub_addr), .sccb_data_in(sccb_data_in), .sccb_data_out(sccb_data_out),
    .sccb_done(sccb_done), .busy(busy), .init_done(init_done), .error(error), .err_addr(err_addr)
  );
  logic [15:0] rom [256];
  always @(posedge xclk) tbl_data <= rom[tbl_addr];
  int n_cmp = 0;
  int n_bad = 0;
  logic [24:0] exp_x [$];
  logic [7:0] exp_ack [$];
  bit hang = 1'b0;
  int done_hold = 0;
  int lat_cnt = 0;
  int hold_cnt = 0;
  logic [7:0] rd_fixed = 8'h00;
  logic [7:0] rd_fixed_addr = 8'h0A;
  logic [7:0] rd_bias = 8'h00;
  logic [24:0] cur, snap;
  bit unstable = 1'b0;
  logic start_prev = 1'b0;
  logic ack_prev = 1'b0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic push_wr(input logic [7:0] sub, input logic [7:0] data);
    exp_x.push_back({1'b0, 8'h42, sub, data});
`ifdef SCCB_READBACK_EN
    exp_x.push_back({1'b1, 8'h42, sub, data});
`endif
  endtask
  task automatic pulse_go();
    @(negedge xclk);
    go = 1'b1;
    @(negedge xclk);
    go = 1'b0;
  endtask
  task automatic wait_idle(input string name, input int budget, output int cyc);
    cyc = 0;
    do begin
      @(posedge xclk);
      #1;
      cyc++;
    end while (busy && cyc < budget);
    chk({name, "_idle"}, busy, 0);
  endtask
  task automatic wait_ack(input string name, input int budget);
    int cyc = 0;
    do begin
      @(posedge xclk);
      #1;
      cyc++;
    end while (!host_ack && cyc < budget);
    chk({name, "_ack"}, host_ack, 1);
    host_req = 1'b0;
  endtask
  task automatic host_xfer(input string name, input logic rw, input logic [7:0] addr,
                           input logic [7:0] wd, input logic [7:0] exp_rd);
    exp_x.push_back({rw, 8'h42, addr, wd});
    exp_ack.push_back(exp_rd);
    @(negedge xclk);
    host_req = 1'b1;
    host_rw = rw;
    host_addr = addr;
    host_wdata = wd;
    wait_ack(name, 600);
  endtask
  task automatic load_rom(input logic [15:0] fill);
    for (int i = 0; i < 256; i++) rom[i] = fill;
  endtask
  initial begin
    sccb_done = 1'b0;
    sccb_data_out = 8'h00;
    forever begin
      @(negedge xclk);
      if (sccb_done) begin
        if (!sccb_start) begin
          if (hold_cnt >= done_hold) begin
            sccb_done = 1'b0;
            hold_cnt = 0;
          end else hold_cnt++;
        end
      end else if (sccb_start && !hang) begin
        if (lat_cnt >= 3) begin
          lat_cnt = 0;
          sccb_done = 1'b1;
          sccb_data_out = (sccb_sub_addr == rd_fixed_addr) ? rd_fixed : sccb_data_in + rd_bias;
        end else lat_cnt++;
      end else lat_cnt = 0;
    end
  end
  initial begin
    forever begin
      @(posedge xclk);
      #1;
      cur = {sccb_rw, sccb_ip_addr, sccb_sub_addr, sccb_data_in};
      if (sccb_start && !start_prev) begin
        chk("done_low_at_start", sccb_done, 0);
        chk("xfer_pending", exp_x.size() > 0, 1);
        if (exp_x.size() > 0) chk("xfer_fields", cur, exp_x.pop_front());
        snap = cur;
        unstable = 1'b0;
      end else if (sccb_start && start_prev && cur != snap) unstable = 1'b1;
      if (!sccb_start && start_prev) chk("xfer_stable", unstable, 0);
      if (host_ack) begin
        chk("ack_single", ack_prev, 0);
        chk("ack_pending", exp_ack.size() > 0, 1);
        if (exp_ack.size() > 0) chk("host_rdata", host_rdata, exp_ack.pop_front());
      end
      start_prev = sccb_start;
      ack_prev = host_ack;
    end
  end
  initial begin
    #500_000;
    $display("FAIL watchdog: got running want finished");
    $fatal(1);
  end
  initial begin
    int cyc;
    host_req = 1'b0;
    host_rw = 1'b0;
    host_addr = 8'h00;
    host_wdata = 8'h00;
    load_rom(16'hFFFF);
    repeat (3) @(negedge xclk);
    chk("rst_busy", busy, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_error", error, 0);
    chk("rst_err_addr", err_addr, 0);
    chk("rst_start", sccb_start, 0);
    chk("rst_tbl_addr", tbl_addr, 0);
    chk("rst_ack", host_ack, 0);
    chk("rst_ip_addr", sccb_ip_addr, 0);
    resetn = 1'b1;
    rom[0] = 16'h1280;
    rom[1] = 16'hFE05;
    rom[2] = 16'hFFFF;
    push_wr(8'h12, 8'h80);
    pulse_go();
    wait_idle("t1", 300, cyc);
    chk("t1_init_done", init_done, 1);
    chk("t1_error", error, 0);
    chk("t1_delay_window", cyc >= 55 && cyc <= 90, 1);
    chk("t1_xfers_done", exp_x.size(), 0);
    done_hold = 3;
    rom[0] = 16'h1011;
    rom[1] = 16'h2022;
    rom[2] = 16'hFFFF;
    push_wr(8'h10, 8'h11);
    push_wr(8'h20, 8'h22);
    pulse_go();
    wait_idle("t2", 300, cyc);
    chk("t2_init_done", init_done, 1);
    chk("t2_xfers_done", exp_x.size(), 0);
    done_hold = 0;
    rd_fixed_addr = 8'h0A;
    rd_fixed = 8'h76;
    host_xfer("t3_read", 1'b1, 8'h0A, 8'h00, 8'h76);
    host_xfer("t3_write", 1'b0, 8'h33, 8'h55, 8'h76);
    chk("t3_acks_done", exp_ack.size(), 0);
    rom[0] = 16'h4411;
    rom[1] = 16'hFFFF;
    rd_fixed_addr = 8'h0B;
    rd_fixed = 8'h99;
    push_wr(8'h44, 8'h11);
    exp_x.push_back({1'b1, 8'h42, 8'h0B, 8'h00});
    exp_ack.push_back(8'h99);
    @(negedge xclk);
    go = 1'b1;
    host_req = 1'b1;
    host_rw = 1'b1;
    host_addr = 8'h0B;
    host_wdata = 8'h00;
    @(negedge xclk);
    go = 1'b0;
    wait_ack("t4", 600);
    chk("t4_init_done", init_done, 1);
    chk("t4_xfers_done", exp_x.size(), 0);
    hang = 1'b1;
    rd_fixed_addr = 8'h0C;
    host_xfer("th_tmo", 1'b1, 8'h0C, 8'h00, 8'h99);
    chk("th_tmo_error", error, 1);
    hang = 1'b0;
    load_rom(16'hFE00);
    pulse_go();
    wait_idle("wrap", 2000, cyc);
    chk("wrap_error", error, 1);
    chk("wrap_err_addr", err_addr, 8'hFF);
    chk("wrap_init_done", init_done, 0);
    load_rom(16'hFFFF);
    hang = 1'b1;
    rom[0] = 16'h1280;
    exp_x.push_back({1'b0, 8'h42, 8'h12, 8'h80});
    pulse_go();
    wait_idle("t5", 400, cyc);
    chk("t5_error", error, 1);
    chk("t5_err_addr", err_addr, 0);
    chk("t5_start", sccb_start, 0);
    chk("t5_init_done", init_done, 0);
    chk("t5_tmo_window", cyc >= TMO && cyc <= TMO + 15, 1);
    hang = 1'b0;
    repeat (3) @(negedge xclk);
    rd_bias = 8'h01;
    push_wr(8'h12, 8'h80);
    pulse_go();
    wait_idle("rb", 300, cyc);
    chk("rb_init_done", init_done, 1);
`ifdef SCCB_READBACK_EN
    chk("rb_error", error, 1);
    chk("rb_err_addr", err_addr, 0);
`else
    chk("rb_error", error, 0);
`endif
    rd_bias = 8'h00;
    hang = 1'b1;
    exp_x.push_back({1'b0, 8'h42, 8'h12, 8'h80});
    pulse_go();
    cyc = 0;
    do begin
      @(posedge xclk);
      #1;
      cyc++;
    end while (!sccb_start && cyc < 20);
    chk("rm_start", sccb_start, 1);
    @(negedge xclk);
    resetn = 1'b0;
    @(posedge xclk);
    #1;
    chk("rm_start_drop", sccb_start, 0);
    chk("rm_busy", busy, 0);
    chk("rm_err_addr", err_addr, 0);
    @(negedge xclk);
    resetn = 1'b1;
    hang = 1'b0;
    repeat (5) @(negedge xclk);
    chk("rm_no_resume", busy, 0);
    chk("all_xfers_seen", exp_x.size(), 0);
    chk("all_acks_seen", exp_ack.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
